// File: rtl/fpu_norm_pkg.sv
// Shared types and helpers for the FPU normalization back-end.
// Default widths match the production FPU datapath.
package fpu_norm_pkg;

  localparam int DEF_MAN_WIDTH = 27;
  localparam int DEF_EXP_WIDTH = 10;
  localparam int DEF_TAG_WIDTH = 5;
  localparam int DEF_CNT_WIDTH = $clog2(DEF_MAN_WIDTH);

  typedef struct packed {
    logic [DEF_MAN_WIDTH-1:0] man;
    logic [DEF_EXP_WIDTH-1:0] exp;
    logic [DEF_CNT_WIDTH-1:0] shift;
    logic [DEF_TAG_WIDTH-1:0] tag;
    logic                     zero;
    logic                     denorm;
  } norm_s1_t;

  // Shift is bounded by the LZC (saturated) and by the subnormal floor.
  function automatic int clamp_shift(
    input int cnt,
    input int allowed,
    input int max_cnt
  );
    int c;
    c = (cnt > max_cnt) ? max_cnt : cnt;
    if (allowed <= 0) return 0;
    if (c <= allowed) return c;
    return allowed;
  endfunction

endpackage

// File: rtl/norm_lshift.sv
// Combinational log2-stage barrel left shifter.
// Zeros are shifted in at the LSB.
module norm_lshift #(
  parameter int MAN_WIDTH = 27,
  localparam int SH_WIDTH = $clog2(MAN_WIDTH)
) (
  input  logic [MAN_WIDTH-1:0] man,
  input  logic [SH_WIDTH-1:0]  shift,
  output logic [MAN_WIDTH-1:0] result
);

  logic [MAN_WIDTH-1:0] stage [SH_WIDTH+1];

  assign stage[0] = man;

  for (genvar g = 0; g < SH_WIDTH; g++) begin : g_stage
    assign stage[g+1] = shift[g] ? (stage[g] << (2**g))
                                 : stage[g];
  end

  assign result = stage[SH_WIDTH];

endmodule

// File: rtl/fpu_norm_shift.sv
// Normalization shift + exponent adjust, 2-stage valid/ready pipe.
// FPU_NORM_SELF_LZC_EN: compute count/empty locally from in_man_i.
module fpu_norm_shift
  import fpu_norm_pkg::*;
#(
  parameter int MAN_WIDTH = DEF_MAN_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  localparam int CNT_WIDTH = $clog2(MAN_WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [MAN_WIDTH-1:0] in_man_i,
  input  logic [EXP_WIDTH-1:0] in_exp_i,
  input  logic [CNT_WIDTH-1:0] in_cnt_i,
  input  logic                 in_empty_i,
  input  logic [TAG_WIDTH-1:0] in_tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [MAN_WIDTH-1:0] out_man_o,
  output logic [EXP_WIDTH-1:0] out_exp_o,
  output logic [TAG_WIDTH-1:0] out_tag_o,
  output logic                 out_zero_o,
  output logic                 out_denorm_o
);

  typedef struct packed {
    logic [MAN_WIDTH-1:0] man;
    logic [EXP_WIDTH-1:0] exp;
    logic [CNT_WIDTH-1:0] shift;
    logic [TAG_WIDTH-1:0] tag;
    logic                 zero;
    logic                 denorm;
  } s1_t;

  s1_t s1_d;
  s1_t s1_q;

  logic                 v1_q;
  logic                 v2_q;
  logic                 adv2;
  logic [MAN_WIDTH-1:0] sh_man;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 empty;

  int exp_s;
  int allowed;
  int cnt_sat;
  int sh_amt;

`ifdef FPU_NORM_SELF_LZC_EN
  always_comb begin
    cnt   = '0;
    empty = ~|in_man_i;
    for (int i = 0; i < MAN_WIDTH; i++)
      if (in_man_i[i])
        cnt = CNT_WIDTH'(MAN_WIDTH - 1 - i);
  end
`else
  assign cnt   = in_cnt_i;
  assign empty = in_empty_i;
`endif

  always_comb begin
    exp_s   = int'($signed(in_exp_i));
    allowed = exp_s - 1;
    cnt_sat = (int'(cnt) > MAN_WIDTH - 1)
            ? MAN_WIDTH - 1 : int'(cnt);
    sh_amt  = clamp_shift(int'(cnt), allowed,
                          MAN_WIDTH - 1);
    s1_d     = '0;
    s1_d.tag = in_tag_i;
    if (empty) begin
      s1_d.zero = 1'b1;
    end else begin
      s1_d.man   = in_man_i;
      s1_d.shift = CNT_WIDTH'(sh_amt);
      if (allowed > 0 && cnt_sat <= allowed)
        s1_d.exp = EXP_WIDTH'(exp_s - cnt_sat);
      else
        s1_d.denorm = 1'b1;
    end
  end

  norm_lshift #(
    .MAN_WIDTH(MAN_WIDTH)
  ) u_lshift (
    .man   (s1_q.man),
    .shift (s1_q.shift),
    .result(sh_man)
  );

  // A stage accepts when empty or when its contents move on.
  assign adv2       = ~v2_q | out_ready_i;
  assign in_ready_o = ~v1_q | adv2;
  assign out_valid_o = v2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      s1_q         <= '0;
      out_man_o    <= '0;
      out_exp_o    <= '0;
      out_tag_o    <= '0;
      out_zero_o   <= 1'b0;
      out_denorm_o <= 1'b0;
    end else begin
      if (in_ready_o) begin
        v1_q <= in_valid_i;
        s1_q <= s1_d;
      end
      if (adv2) begin
        v2_q         <= v1_q;
        out_man_o    <= sh_man;
        out_exp_o    <= s1_q.exp;
        out_tag_o    <= s1_q.tag;
        out_zero_o   <= s1_q.zero;
        out_denorm_o <= s1_q.denorm;
      end
    end
  end

endmodule
